// File: rtl/alu_pkg.sv
// Shared types for the ALU command packet parser: opcodes, error causes and
// parser states.
package alu_pkg;

  localparam int HDR_BYTES = 4;

  typedef enum logic [7:0] {
    OP_ECHO = 8'hEC,
    OP_ADD  = 8'hAD,
    OP_MUL  = 8'h88,
    OP_DIV  = 8'hD0
  } opcode_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_OPCODE  = 2'd1,
    ERR_LENGTH  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_HDR0,
    ST_HDR1,
    ST_HDR2,
    ST_HDR3,
    ST_ECHO,
    ST_COLLECT,
    ST_OUT,
    ST_DRAIN
  } state_e;

  function automatic logic is_arith(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_word_packer.sv
// Packs four consecutive payload bytes into a little-endian 32-bit operand
// word and holds it (full) until the consumer pops it.
module alu_word_packer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  input  logic        pop_i,
  output logic [31:0] word_o,
  output logic [1:0]  idx_o,
  output logic        full_o
);

  logic [31:0] word_q;
  logic [1:0]  idx_q;
  logic        full_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      word_q <= '0;
      idx_q  <= '0;
      full_q <= 1'b0;
    end else begin
      // Shifting right puts the first byte of a group at bits [7:0].
      if (push_i && !full_q) begin
        word_q <= {byte_i, word_q[31:8]};
        idx_q  <= idx_q + 2'd1;
        if (idx_q == 2'd3) full_q <= 1'b1;
      end
      if (pop_i) full_q <= 1'b0;
    end
  end

  assign word_o = word_q;
  assign idx_o  = idx_q;
  assign full_o = full_q;

endmodule

// File: rtl/alu_packet_parser.sv
// Parses the UART RX byte stream into ALU command packets (echo bytes or
// packed operand words). Optional idle timeout: define ALU_PARSER_TIMEOUT_EN.
module alu_packet_parser
  import alu_pkg::*;
`ifdef ALU_PARSER_TIMEOUT_EN
  #(parameter int unsigned TIMEOUT_CYCLES = 1_000_000)
`endif
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  opcode_o,
  output logic        pkt_start_o,
  output logic [7:0]  echo_data_o,
  output logic        echo_valid_o,
  input  logic        echo_ready_i,
  output logic [31:0] op_data_o,
  output logic        op_valid_o,
  output logic        op_last_o,
  input  logic        op_ready_i,
  output logic        err_o,
  output logic [1:0]  err_code_o
);

  state_e      state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] remain_q, remain_d;
  logic [15:0] len;
  logic        err_q, err_fire;
  err_code_e   err_code_q, err_cause;
  logic        start_q, start_fire;
  logic        push, abort, accept, timeout_hit;
  logic [31:0] pk_word;
  logic [1:0]  pk_idx;
  logic        pk_full;

  // Ready depends only on state and downstream ready, keeping accept loop-free.
  always_comb begin
    unique case (state_q)
      ST_ECHO: rx_ready_o = echo_ready_i;
      ST_OUT:  rx_ready_o = 1'b0;
      default: rx_ready_o = 1'b1;
    endcase
  end

  assign accept = rx_valid_i & rx_ready_o;
  assign len    = {rx_data_i, len_lo_q};

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    len_lo_d   = len_lo_q;
    remain_d   = remain_q;
    err_fire   = 1'b0;
    err_cause  = ERR_NONE;
    start_fire = 1'b0;
    push       = 1'b0;
    abort      = 1'b0;

    unique case (state_q)
      ST_HDR0: if (accept) begin
        opcode_d = rx_data_i;
        state_d  = ST_HDR1;
      end
      ST_HDR1: if (accept) state_d = ST_HDR2;
      ST_HDR2: if (accept) begin
        len_lo_d = rx_data_i;
        state_d  = ST_HDR3;
      end
      ST_HDR3: if (accept) begin
        remain_d = len - 16'(HDR_BYTES);
        if (len < 16'(HDR_BYTES)) begin
          err_fire  = 1'b1;
          err_cause = ERR_LENGTH;
          state_d   = ST_HDR0;
        end else if (len == 16'(HDR_BYTES)) begin
          start_fire = 1'b1;
          state_d    = ST_HDR0;
        end else if (opcode_q == OP_ECHO) begin
          start_fire = 1'b1;
          state_d    = ST_ECHO;
        end else if (is_arith(opcode_q)) begin
          // Arithmetic payloads need at least two whole operand words.
          if (remain_d[1:0] == 2'd0 && remain_d >= 16'd8) begin
            start_fire = 1'b1;
            state_d    = ST_COLLECT;
          end else begin
            err_fire  = 1'b1;
            err_cause = ERR_LENGTH;
            state_d   = ST_DRAIN;
          end
        end else begin
          err_fire  = 1'b1;
          err_cause = ERR_OPCODE;
          state_d   = ST_DRAIN;
        end
      end
      ST_ECHO, ST_DRAIN: if (accept) begin
        remain_d = remain_q - 16'd1;
        if (remain_q == 16'd1) state_d = ST_HDR0;
      end
      ST_COLLECT: if (accept) begin
        push     = 1'b1;
        remain_d = remain_q - 16'd1;
        if (pk_idx == 2'd3) state_d = ST_OUT;
      end
      ST_OUT: if (pk_full && op_ready_i) begin
        state_d = (remain_q == 16'd0) ? ST_HDR0 : ST_COLLECT;
      end
      default: state_d = ST_HDR0;
    endcase

    if (timeout_hit) begin
      state_d   = ST_HDR0;
      abort     = 1'b1;
      err_fire  = 1'b1;
      err_cause = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_HDR0;
      opcode_q   <= '0;
      len_lo_q   <= '0;
      remain_q   <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      start_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      len_lo_q <= len_lo_d;
      remain_q <= remain_d;
      err_q    <= err_fire;
      start_q  <= start_fire;
      if (err_fire) err_code_q <= err_cause;
    end
  end

`ifdef ALU_PARSER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] idle_cnt_q;
  logic             idle_tick;

  // An echo stalled by the downstream sink is not an idle sender.
  assign idle_tick = !accept && (state_q != ST_HDR0) && (state_q != ST_OUT) &&
                     !(state_q == ST_ECHO && rx_valid_i);
  assign timeout_hit = idle_tick && (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || accept || state_q == ST_HDR0 || timeout_hit) begin
      idle_cnt_q <= '0;
    end else if (idle_tick) begin
      idle_cnt_q <= idle_cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  alu_word_packer u_packer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (abort),
    .push_i  (push),
    .byte_i  (rx_data_i),
    .pop_i   (pk_full & op_ready_i),
    .word_o  (pk_word),
    .idx_o   (pk_idx),
    .full_o  (pk_full)
  );

  assign opcode_o     = opcode_q;
  assign pkt_start_o  = start_q;
  assign echo_data_o  = rx_data_i;
  assign echo_valid_o = (state_q == ST_ECHO) & rx_valid_i;
  assign op_data_o    = pk_word;
  assign op_valid_o   = pk_full;
  assign op_last_o    = pk_full & (remain_q == 16'd0);
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_alu_packet_parser.sv
// Self-checking bench for alu_packet_parser: directed table, hand-written
// corner sequences and randomized packets against a packet-level model.
module tb_alu_packet_parser;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  opcode_o;
  logic        pkt_start_o;
  logic [7:0]  echo_data_o;
  logic        echo_valid_o;
  logic        echo_ready_i;
  logic [31:0] op_data_o;
  logic        op_valid_o;
  logic        op_last_o;
  logic        op_ready_i;
  logic        err_o;
  logic [1:0]  err_code_o;

  always #5 clk_i = ~clk_i;

`ifdef ALU_PARSER_TIMEOUT_EN
  alu_packet_parser #(.TIMEOUT_CYCLES(16)) dut (
`else
  alu_packet_parser dut (
`endif
    .clk_i(clk_i), .rst_i(rst_i), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o), .opcode_o(opcode_o), .pkt_start_o(pkt_start_o),
    .echo_data_o(echo_data_o), .echo_valid_o(echo_valid_o), .echo_ready_i(echo_ready_i),
    .op_data_o(op_data_o), .op_valid_o(op_valid_o), .op_last_o(op_last_o),
    .op_ready_i(op_ready_i), .err_o(err_o), .err_code_o(err_code_o)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Observed and expected event streams.
  logic [7:0]  mon_echo[$],   exp_echo[$];
  logic [32:0] mon_ops[$],    exp_ops[$];
  logic [1:0]  mon_errs[$],   exp_errs[$];
  logic [7:0]  mon_starts[$], exp_starts[$];

  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (echo_valid_o && echo_ready_i) mon_echo.push_back(echo_data_o);
      if (op_valid_o && op_ready_i)     mon_ops.push_back({op_last_o, op_data_o});
      if (err_o)                        mon_errs.push_back(err_code_o);
      if (pkt_start_o)                  mon_starts.push_back(opcode_o);
    end
  end

  function automatic void clear_all();
    mon_echo.delete();   exp_echo.delete();
    mon_ops.delete();    exp_ops.delete();
    mon_errs.delete();   exp_errs.delete();
    mon_starts.delete(); exp_starts.delete();
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int  n = 0;
    bit  done = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk_i);
      if (rx_ready_o) done = 1;
      @(posedge clk_i); #1;
      n++;
    end
    rx_valid_i = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL send_byte: byte 0x%0h not accepted within 200 cycles", b);
    end
  endtask

  task automatic send_pkt(input logic [7:0] p[$], input int gap_max);
    foreach (p[i]) begin
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk_i); #1; end
      send_byte(p[i]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  // Packet-level reference: what one whole packet must produce downstream.
  function automatic void model(input logic [7:0] p[$]);
    int         len;
    int         nw;
    logic [7:0] op;
    op  = p[0];
    len = int'({p[3], p[2]});
    if (len < 4) exp_errs.push_back(2'd2);
    else if (len == 4) exp_starts.push_back(op);
    else if (op == 8'hEC) begin
      exp_starts.push_back(op);
      for (int i = 4; i < len; i++) exp_echo.push_back(p[i]);
    end else if (op == 8'hAD || op == 8'h88 || op == 8'hD0) begin
      if ((len - 4) % 4 == 0 && len - 4 >= 8) begin
        exp_starts.push_back(op);
        nw = (len - 4) / 4;
        for (int w = 0; w < nw; w++)
          exp_ops.push_back({w == nw - 1, p[4*w+7], p[4*w+6], p[4*w+5], p[4*w+4]});
      end else exp_errs.push_back(2'd2);
    end else exp_errs.push_back(2'd1);
  endfunction

  typedef struct {
    int           n;
    logic [127:0] bytes;      // right-aligned, first byte most significant
    int           exp_errs;
    logic [1:0]   exp_code;
    int           exp_starts;
    int           exp_echo_n;
    logic [31:0]  exp_echo_cat;
    int           exp_words;
    logic [31:0]  exp_first;
    logic [31:0]  exp_last;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [127:0] b, input int errs,
                              input logic [1:0] code, input int starts, input int echo_n,
                              input logic [31:0] echo_cat, input int words,
                              input logic [31:0] first, input logic [31:0] last);
    vec_t v;
    v.n = n; v.bytes = b; v.exp_errs = errs; v.exp_code = code; v.exp_starts = starts;
    v.exp_echo_n = echo_n; v.exp_echo_cat = echo_cat; v.exp_words = words;
    v.exp_first = first; v.exp_last = last;
    return v;
  endfunction

  function automatic logic [7:0] vbyte(input vec_t v, input int k);
    return v.bytes[8*(v.n-1-k) +: 8];
  endfunction

  localparam int NV = 10;
  vec_t vt[NV];
  bit   bp_on = 0;

  initial begin
    logic [31:0] cat;
    logic [7:0]  pk[$];
    int          lasts;
    int          n;
    bit          seen;

    rst_i = 1'b1; rx_valid_i = 1'b0; rx_data_i = '0;
    echo_ready_i = 1'b1; op_ready_i = 1'b1;

    vt[0] = mk(7,  {8'hEC,8'h00,8'h07,8'h00,8'h61,8'h62,8'h63}, 0, 0, 1, 3, 32'h616263, 0, 0, 0);
    vt[1] = mk(12, {8'hAD,8'h00,8'h0C,8'h00,8'h01,8'h00,8'h00,8'h00,8'h02,8'h00,8'h00,8'h00},
               0, 0, 1, 0, 0, 2, 32'h1, 32'h2);
    vt[2] = mk(6,  {8'h55,8'h00,8'h06,8'h00,8'hAA,8'hBB}, 1, 2'd1, 0, 0, 0, 0, 0, 0);
    vt[3] = mk(5,  {8'hEC,8'h00,8'h05,8'h00,8'h5A}, 0, 0, 1, 1, 32'h5A, 0, 0, 0);
    vt[4] = mk(10, {8'hAD,8'h00,8'h0A,8'h00,8'h11,8'h22,8'h33,8'h44,8'h55,8'h66},
               1, 2'd2, 0, 0, 0, 0, 0, 0);
    vt[5] = mk(4,  {8'hEC,8'h00,8'h03,8'h00}, 1, 2'd2, 0, 0, 0, 0, 0, 0);
    vt[6] = mk(4,  {8'hEC,8'h00,8'h04,8'h00}, 0, 0, 1, 0, 0, 0, 0, 0);
    vt[7] = mk(16, {8'h88,8'h00,8'h10,8'h00,8'h11,8'h22,8'h33,8'h44,8'h55,8'h66,8'h77,8'h88,
                    8'h99,8'hAA,8'hBB,8'hCC}, 0, 0, 1, 0, 0, 3, 32'h44332211, 32'hCCBBAA99);
    vt[8] = mk(8,  {8'hD0,8'h00,8'h08,8'h00,8'h01,8'h02,8'h03,8'h04}, 1, 2'd2, 0, 0, 0, 0, 0, 0);
    vt[9] = mk(13, {8'hAD,8'h00,8'h0D,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,8'h09},
               1, 2'd2, 0, 0, 0, 0, 0, 0);

    idle(3);
    rst_i = 1'b0;

    // Reset state.
    @(negedge clk_i);
    check("reset rx_ready", rx_ready_o, 1);
    check("reset op_valid", op_valid_o, 0);
    check("reset op_data", op_data_o, 0);
    check("reset opcode", opcode_o, 0);
    check("reset err", err_o, 0);
    check("reset err_code", err_code_o, 0);
    check("reset pkt_start", pkt_start_o, 0);
    check("reset echo_valid", echo_valid_o, 0);
    @(posedge clk_i); #1;

    // Directed table.
    for (int i = 0; i < NV; i++) begin
      clear_all();
      for (int k = 0; k < vt[i].n; k++) send_byte(vbyte(vt[i], k));
      idle(4);
      check($sformatf("v%0d err count", i), mon_errs.size(), vt[i].exp_errs);
      if (vt[i].exp_errs > 0 && mon_errs.size() > 0)
        check($sformatf("v%0d err code", i), mon_errs[0], vt[i].exp_code);
      check($sformatf("v%0d start count", i), mon_starts.size(), vt[i].exp_starts);
      if (vt[i].exp_starts > 0 && mon_starts.size() > 0)
        check($sformatf("v%0d start opcode", i), mon_starts[0], vbyte(vt[i], 0));
      check($sformatf("v%0d echo count", i), mon_echo.size(), vt[i].exp_echo_n);
      if (vt[i].exp_echo_n > 0) begin
        cat = '0;
        foreach (mon_echo[j]) cat = (cat << 8) | 32'(mon_echo[j]);
        check($sformatf("v%0d echo bytes", i), cat, vt[i].exp_echo_cat);
      end
      check($sformatf("v%0d word count", i), mon_ops.size(), vt[i].exp_words);
      if (vt[i].exp_words > 0 && mon_ops.size() > 0) begin
        lasts = 0;
        foreach (mon_ops[j]) lasts += int'(mon_ops[j][32]);
        check($sformatf("v%0d first word", i), mon_ops[0][31:0], vt[i].exp_first);
        check($sformatf("v%0d last word", i), mon_ops[mon_ops.size()-1][31:0], vt[i].exp_last);
        check($sformatf("v%0d last flag count", i), lasts, 1);
        check($sformatf("v%0d last flag on final", i), mon_ops[mon_ops.size()-1][32], 1);
      end
    end

    // Backpressure on the ALU: word 1 held stable and input stalled.
    clear_all();
    op_ready_i = 1'b0;
    pk = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
    send_pkt(pk, 0);
    rx_data_i = 8'h02; rx_valid_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check($sformatf("hold c%0d op_valid", c), op_valid_o, 1);
      check($sformatf("hold c%0d op_data", c), op_data_o, 32'h1);
      check($sformatf("hold c%0d op_last", c), op_last_o, 0);
      check($sformatf("hold c%0d rx_ready", c), rx_ready_o, 0);
      @(posedge clk_i); #1;
    end
    op_ready_i = 1'b1;
    pk = '{8'h02, 8'h00, 8'h00, 8'h00};
    send_pkt(pk, 0);
    idle(4);
    check("hold word count", mon_ops.size(), 2);
    if (mon_ops.size() == 2) begin
      check("hold word1", mon_ops[0], {1'b0, 32'h1});
      check("hold word2", mon_ops[1], {1'b1, 32'h2});
    end

    // Echo ending, then next header with no bubble even while TX is stalled.
    clear_all();
    pk = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h41, 8'h42};
    send_pkt(pk, 0);
    echo_ready_i = 1'b0;
    @(negedge clk_i);
    check("no bubble after echo", rx_ready_o, 1);
    check("echo_valid idle", echo_valid_o, 0);
    @(posedge clk_i); #1;
    echo_ready_i = 1'b1;
    pk = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h43};
    send_pkt(pk, 0);
    idle(2);
    cat = '0;
    foreach (mon_echo[j]) cat = (cat << 8) | 32'(mon_echo[j]);
    check("b2b echo bytes", cat, 32'h414243);
    check("b2b starts", mon_starts.size(), 2);

    // Reset in the middle of an operand word.
    clear_all();
    pk = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02};
    send_pkt(pk, 0);
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check($sformatf("post-reset c%0d op_valid", c), op_valid_o, 0);
      check($sformatf("post-reset c%0d rx_ready", c), rx_ready_o, 1);
      @(posedge clk_i); #1;
    end
    pk = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h06, 8'h07, 8'h08,
           8'h09, 8'h0A, 8'h0B, 8'h0C};
    send_pkt(pk, 0);
    idle(4);
    check("post-reset word count", mon_ops.size(), 2);
    if (mon_ops.size() == 2) begin
      check("post-reset word1", mon_ops[0], {1'b0, 32'h08070605});
      check("post-reset word2", mon_ops[1], {1'b1, 32'h0C0B0A09});
    end
    check("post-reset errs", mon_errs.size(), 0);

    // Randomized packets with gaps and downstream backpressure.
    clear_all();
    bp_on = 1;
    fork
      while (bp_on) begin
        @(posedge clk_i); #1;
        echo_ready_i = ($urandom_range(0, 3) != 0);
        op_ready_i   = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int t = 0; t < 150; t++) begin
      int         kind;
      int         len;
      logic [7:0] op;
      logic [7:0] arith_ops[3];
      arith_ops = '{8'hAD, 8'h88, 8'hD0};
      kind = $urandom_range(0, 5);
      case (kind)
        0: begin op = 8'hEC; len = $urandom_range(5, 12); end
        1: begin op = arith_ops[$urandom_range(0, 2)]; len = 4 + 4 * $urandom_range(2, 4); end
        2: begin
          op  = arith_ops[$urandom_range(0, 2)];
          len = $urandom_range(5, 15);
          if ((len - 4) % 4 == 0 && len >= 12) len++;
        end
        3: begin
          do op = 8'($urandom); while (op == 8'hEC || op == 8'hAD || op == 8'h88 || op == 8'hD0);
          len = $urandom_range(5, 10);
        end
        4: begin op = 8'($urandom); len = $urandom_range(0, 3); end
        default: begin op = 8'($urandom); len = 4; end
      endcase
      pk = '{op, 8'($urandom), 8'(len), 8'(len >> 8)};
      for (int i = 4; i < len; i++) pk.push_back(8'($urandom));
      model(pk);
      send_pkt(pk, 2);
    end
    bp_on = 0;
    idle(2);
    echo_ready_i = 1'b1;
    op_ready_i   = 1'b1;
    idle(10);
    check("rand echo count", mon_echo.size(), exp_echo.size());
    check("rand word count", mon_ops.size(), exp_ops.size());
    check("rand err count", mon_errs.size(), exp_errs.size());
    check("rand start count", mon_starts.size(), exp_starts.size());
    for (int i = 0; i < mon_echo.size() && i < exp_echo.size(); i++)
      check($sformatf("rand echo[%0d]", i), mon_echo[i], exp_echo[i]);
    for (int i = 0; i < mon_ops.size() && i < exp_ops.size(); i++)
      check($sformatf("rand word[%0d] {last,data}", i), mon_ops[i], exp_ops[i]);
    for (int i = 0; i < mon_errs.size() && i < exp_errs.size(); i++)
      check($sformatf("rand err[%0d]", i), mon_errs[i], exp_errs[i]);
    for (int i = 0; i < mon_starts.size() && i < exp_starts.size(); i++)
      check($sformatf("rand start[%0d]", i), mon_starts[i], exp_starts[i]);

`ifdef ALU_PARSER_TIMEOUT_EN
    // Sender goes silent mid-packet: abort after 16 idle cycles.
    clear_all();
    pk = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01};
    send_pkt(pk, 0);
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk_i);
      n++;
      if (err_o) seen = 1;
    end
    check("timeout latency", n, 17);
    check("timeout code", err_code_o, 2'd3);
    check("timeout rx_ready", rx_ready_o, 1);
    check("timeout op_valid", op_valid_o, 0);
    @(posedge clk_i); #1;
    pk = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h77};
    send_pkt(pk, 0);
    idle(2);
    check("timeout recovery echo count", mon_echo.size(), 1);
    check("timeout no words", mon_ops.size(), 0);
`else
    seen = 0;
    n = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
